// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus shared by the fetch stage (master)
// and the instruction memory or cache (slave).
interface fetch_stage_if;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] imem_rdata;
    logic        imem_resp;

    modport master (
        output imem_read,
        output imem_address,
        input  imem_rdata,
        input  imem_resp
    );

    modport slave (
        input  imem_read,
        input  imem_address,
        output imem_rdata,
        output imem_resp
    );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage: PC, imem request control, one-entry skid
// buffer and the IF/ID register, with execute-stage redirect flushing.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master imem,
    input  logic          i_stall,
    input  logic          i_redirect,
    input  logic [31:0]   i_redirect_pc,
    output logic          o_if_valid,
    output logic [31:0]   o_if_pc,
    output logic [31:0]   o_if_instr,
    output logic [31:0]   o_if_u_imm
);
    typedef enum logic [1:0] {
        S_FETCH,
        S_BUFFERED,
        S_DISCARD
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_pend_pc;
    logic [31:0] w_pend_pc_next;
    logic [31:0] r_skid;
    logic [31:0] w_skid_next;
    logic        r_if_valid;
    logic        w_if_valid_next;
    logic [31:0] r_if_pc;
    logic [31:0] w_if_pc_next;
    logic [31:0] r_if_instr;
    logic [31:0] w_if_instr_next;
    logic        w_accept;
    logic        w_load;
    logic [31:0] w_load_pc;
    logic [31:0] w_load_instr;
    logic [31:0] w_redirect_pc;
    logic [31:0] w_pc_plus4;

    assign w_accept      = !r_if_valid || !i_stall;
    assign w_redirect_pc = {i_redirect_pc[31:2], 2'b00};
    assign w_pc_plus4    = r_pc + 32'd4;

    // The request is gated by rst_n so nothing is requested while reset is held.
    assign imem.imem_read    = rst_n && (r_state != S_BUFFERED);
    assign imem.imem_address = r_pc;

    assign o_if_valid = r_if_valid;
    assign o_if_pc    = r_if_pc;
    assign o_if_instr = r_if_instr;
    assign o_if_u_imm = {r_if_instr[31:12], 12'h000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_pend_pc_next  = r_pend_pc;
        w_skid_next     = r_skid;
        w_load          = 1'b0;
        w_load_pc       = r_pc;
        w_load_instr    = imem.imem_rdata;
        w_if_valid_next = r_if_valid;
        w_if_pc_next    = r_if_pc;
        w_if_instr_next = r_if_instr;

        unique case (r_state)
            S_FETCH: begin
                if (i_redirect && imem.imem_resp) begin
                    w_pc_next = w_redirect_pc;
                end else if (i_redirect) begin
                    // Keep the address stable until the outstanding response returns.
                    w_pend_pc_next = w_redirect_pc;
                    w_state_next   = S_DISCARD;
                end else if (imem.imem_resp && w_accept) begin
                    w_load    = 1'b1;
                    w_pc_next = w_pc_plus4;
                end else if (imem.imem_resp) begin
                    w_skid_next  = imem.imem_rdata;
                    w_pc_next    = w_pc_plus4;
                    w_state_next = S_BUFFERED;
                end
            end
            S_BUFFERED: begin
                if (i_redirect) begin
                    w_pc_next    = w_redirect_pc;
                    w_state_next = S_FETCH;
                end else if (w_accept) begin
                    w_load       = 1'b1;
                    w_load_pc    = r_pc - 32'd4;
                    w_load_instr = r_skid;
                    w_state_next = S_FETCH;
                end
            end
            S_DISCARD: begin
                if (i_redirect) begin
                    w_pend_pc_next = w_redirect_pc;
                end
                if (imem.imem_resp) begin
                    w_pc_next    = i_redirect ? w_redirect_pc : r_pend_pc;
                    w_state_next = S_FETCH;
                end
            end
            default: begin
                w_state_next = S_FETCH;
            end
        endcase

        if (i_redirect) begin
            w_if_valid_next = 1'b0;
        end else if (w_load) begin
            w_if_valid_next = 1'b1;
            w_if_pc_next    = w_load_pc;
            w_if_instr_next = w_load_instr;
        end else if (r_if_valid && !i_stall) begin
            w_if_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_pend_pc  <= 32'h0;
            r_skid     <= 32'h0;
            r_if_valid <= 1'b0;
            r_if_pc    <= 32'h0;
            r_if_instr <= 32'h0;
        end else begin
            r_pc       <= w_pc_next;
            r_pend_pc  <= w_pend_pc_next;
            r_skid     <= w_skid_next;
            r_if_valid <= w_if_valid_next;
            r_if_pc    <= w_if_pc_next;
            r_if_instr <= w_if_instr_next;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage: an ideal instruction-stream
// model predicts every word decode consumes, checked by a separate monitor.
module tb_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0060;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        ifValid;
    logic [31:0] ifPc;
    logic [31:0] ifInstr;
    logic [31:0] ifUImm;

    fetch_stage_if bus();

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem          (bus),
        .i_stall       (stall),
        .i_redirect    (redirect),
        .i_redirect_pc (redirectPc),
        .o_if_valid    (ifValid),
        .o_if_pc       (ifPc),
        .o_if_instr    (ifInstr),
        .o_if_u_imm    (ifUImm)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;
    int delivered  = 0;
    int fixedLat   = 0;
    int memRemaining = -1;
    logic [31:0] expQ[$];
    logic [31:0] expTail;

    // Memory contents are a fixed function of the address so a wrong PC shows up.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h0019_660D) ^ 32'h3C6E_F35F;
    endfunction

    function automatic void refill();
        while (expQ.size() < 8) begin
            expTail = expTail + 32'd4;
            expQ.push_back(expTail);
        end
    endfunction

    function automatic void restartStream(input logic [31:0] start);
        expQ.delete();
        expTail = start;
        expQ.push_back(start);
        refill();
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rpc);
        @(negedge clk);
        stall      = s;
        redirect   = r;
        redirectPc = rpc;
        if (r) restartStream(rpc & 32'hFFFF_FFFC);
    endtask

    // Memory responder: variable wait states, one-cycle response strobe.
    initial begin
        bus.imem_resp  = 1'b0;
        bus.imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                bus.imem_resp = 1'b0;
                memRemaining  = -1;
            end else if (bus.imem_read) begin
                if (memRemaining < 0)
                    memRemaining = (fixedLat >= 0) ? fixedLat : int'($urandom_range(0, 3));
                if (memRemaining == 0) begin
                    bus.imem_resp  = 1'b1;
                    bus.imem_rdata = memWord(bus.imem_address);
                    memRemaining   = -1;
                end else begin
                    bus.imem_resp  = 1'b0;
                    bus.imem_rdata = $urandom;
                    memRemaining--;
                end
            end else begin
                bus.imem_resp = 1'b0;
                memRemaining  = -1;
            end
        end
    end

    // Monitor: pops the expected stream whenever decode consumes an instruction.
    initial begin
        logic        prevOpen = 1'b0;
        logic [31:0] prevAddr = 32'h0;
        logic        holdValid = 1'b0;
        logic [31:0] holdPc = 32'h0;
        logic [31:0] holdInstr = 32'h0;
        logic [31:0] e;
        int          idle = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prevOpen  = 1'b0;
                holdValid = 1'b0;
                idle      = 0;
            end else begin
                if (prevOpen) begin
                    checkOutput("read_held", {31'h0, bus.imem_read}, 32'h1);
                    checkOutput("addr_stable", bus.imem_address, prevAddr);
                end
                prevOpen = bus.imem_read && !bus.imem_resp;
                prevAddr = bus.imem_address;

                if (holdValid) begin
                    checkOutput("hold_valid", {31'h0, ifValid}, 32'h1);
                    checkOutput("hold_pc", ifPc, holdPc);
                    checkOutput("hold_instr", ifInstr, holdInstr);
                end
                holdValid = ifValid && stall && !redirect;
                holdPc    = ifPc;
                holdInstr = ifInstr;

                if (ifValid && !stall && !redirect) begin
                    idle = 0;
                    if (expQ.size() == 0) begin
                        checkCount++;
                        $display("[TB] FAIL scoreboard_empty: got pc %h, expected nothing", ifPc);
                    end else begin
                        e = expQ.pop_front();
                        refill();
                        checkOutput("if_pc", ifPc, e);
                        checkOutput("if_instr", ifInstr, memWord(e));
                        checkOutput("if_u_imm", ifUImm, memWord(e) & 32'hFFFF_F000);
                        delivered++;
                    end
                end else if (redirect) begin
                    idle = 0;
                end else begin
                    idle++;
                    if (idle > 100) begin
                        checkCount++;
                        $display("[TB] FAIL watchdog: got %0d idle cycles, expected at most 100", idle);
                        idle = 0;
                    end
                end
            end
        end
    end

    initial begin
        int stallLeft = 0;
        logic s;
        logic r;
        logic [31:0] t;
        logic [31:0] oldAddr;

        stall      = 1'b0;
        redirect   = 1'b0;
        redirectPc = 32'h0;
        restartStream(RESET_PC);

        // Reset values and 0-wait sequential fetch.
        #12;
        checkOutput("rst_valid", {31'h0, ifValid}, 32'h0);
        checkOutput("rst_pc", ifPc, 32'h0);
        checkOutput("rst_instr", ifInstr, 32'h0);
        checkOutput("rst_read", {31'h0, bus.imem_read}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("first_read", {31'h0, bus.imem_read}, 32'h1);
        checkOutput("first_addr", bus.imem_address, 32'h60);
        @(posedge clk); #1;
        checkOutput("second_addr", bus.imem_address, 32'h64);
        checkOutput("first_valid", {31'h0, ifValid}, 32'h1);
        checkOutput("first_if_pc", ifPc, 32'h60);
        @(posedge clk); #1;
        checkOutput("third_addr", bus.imem_address, 32'h68);
        repeat (4) applyStimulus(1'b0, 1'b0, 32'h0);

        // Redirect with same-cycle response while stalled, then stall into skid.
        applyStimulus(1'b1, 1'b1, 32'h0000_1003);
        @(posedge clk); #1;
        checkOutput("redir_valid", {31'h0, ifValid}, 32'h0);
        checkOutput("redir_addr", bus.imem_address, 32'h1000);
        checkOutput("redir_read", {31'h0, bus.imem_read}, 32'h1);
        applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        @(posedge clk); #1;
        checkOutput("skid_read", {31'h0, bus.imem_read}, 32'h0);
        checkOutput("skid_if_pc", ifPc, 32'h1000);
        applyStimulus(1'b1, 1'b0, 32'h0);
        repeat (6) applyStimulus(1'b0, 1'b0, 32'h0);

        // Wrap-around of pc+4 past the top of the address space.
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF8);
        @(posedge clk); #1;
        checkOutput("wrap_addr0", bus.imem_address, 32'hFFFF_FFF8);
        applyStimulus(1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        checkOutput("wrap_addr1", bus.imem_address, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        checkOutput("wrap_addr2", bus.imem_address, 32'h0000_0000);
        repeat (4) applyStimulus(1'b0, 1'b0, 32'h0);

        // 3-wait memory, redirect to 0x200 in the second wait cycle.
        fixedLat = 3;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            #2;
            if (bus.imem_resp) break;
        end
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0200);
        #1;
        oldAddr = bus.imem_address;
        applyStimulus(1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("discard_valid0", {31'h0, ifValid}, 32'h0);
        checkOutput("discard_addr0", bus.imem_address, oldAddr);
        applyStimulus(1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("discard_valid1", {31'h0, ifValid}, 32'h0);
        checkOutput("discard_addr1", bus.imem_address, oldAddr);
        @(posedge clk); #1;
        checkOutput("discard_next_addr", bus.imem_address, 32'h0000_0200);
        repeat (12) applyStimulus(1'b0, 1'b0, 32'h0);

        // Randomized traffic.
        fixedLat = -1;
        for (int c = 0; c < 1500; c++) begin
            if (stallLeft > 0) begin
                s = 1'b1;
                stallLeft--;
            end else if ($urandom_range(0, 99) < 15) begin
                s = 1'b1;
                stallLeft = int'($urandom_range(0, 3));
            end else begin
                s = 1'b0;
            end
            r = ($urandom_range(0, 99) < 4);
            t = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                            : ($urandom & 32'h0000_FFFF);
            applyStimulus(s, r, t);
        end

        // Asynchronous reset while stalled in the discard window.
        fixedLat = 3;
        repeat (6) applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h0000_0400);
        applyStimulus(1'b1, 1'b1, 32'h0000_0500);
        applyStimulus(1'b1, 1'b0, 32'h0);
        #3;
        rst_n = 1'b0;
        restartStream(RESET_PC);
        #1;
        checkOutput("async_valid", {31'h0, ifValid}, 32'h0);
        checkOutput("async_pc", ifPc, 32'h0);
        checkOutput("async_instr", ifInstr, 32'h0);
        checkOutput("async_u_imm", ifUImm, 32'h0);
        checkOutput("async_read", {31'h0, bus.imem_read}, 32'h0);
        checkOutput("async_addr", bus.imem_address, RESET_PC);
        stall    = 1'b0;
        redirect = 1'b0;
        fixedLat = -1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("restart_read", {31'h0, bus.imem_read}, 32'h1);
        checkOutput("restart_addr", bus.imem_address, RESET_PC);
        repeat (60) applyStimulus(1'b0, 1'b0, 32'h0);

        checkOutput("deliveries_min", {31'h0, delivered >= 200}, 32'h1);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
